// File: rtl/fir_requant_pkg.sv
// Shared constants and helpers for the FIR output requantiser.
package fir_requant_pkg;

  localparam int CFG_ADDR_SHIFT = 0;
  localparam int CFG_ADDR_DECIM = 1;

  localparam int SHIFT_RST = 0;
  localparam int DECIM_RST = 1;

  // Clamp a wide signed value into the signed range of a qw-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int qw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (qw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (qw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fir_requant_round.sv
// Combinational round-half-up and arithmetic right shift; one guard bit absorbs the bias.
module fir_requant_round #(
  parameter int OWIDTH = 20,
  parameter int SWIDTH = 5
) (
  input  logic signed [OWIDTH-1:0] din,
  input  logic        [SWIDTH-1:0] shift,
  output logic signed [OWIDTH:0]   dout
);

  logic signed [OWIDTH:0] ext;
  logic signed [OWIDTH:0] bias;
  logic signed [OWIDTH:0] sum;

  always_comb begin
    ext  = {din[OWIDTH-1], din};
    bias = '0;
    if (shift != '0) bias = (OWIDTH+1)'(1) << (shift - SWIDTH'(1));
    sum  = ext + bias;
    dout = sum >>> shift;
  end

endmodule

// File: rtl/fir_dout_requant.sv
// Requantiser behind parallel_fir: round/shift, decimate, saturate, with valid/busy streaming.
module fir_dout_requant
  import fir_requant_pkg::*;
#(
  parameter int OWIDTH = 20,
  parameter int QWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8,
  parameter int SWIDTH = 5,
  parameter int DECW   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_busy,
  input  logic [AWIDTH-1:0]        cfg_addr,
  input  logic [DWIDTH-1:0]        cfg_data,
  input  logic                     din_valid,
  output logic                     din_busy,
  input  logic signed [OWIDTH-1:0] din_data,
  output logic                     dout_valid,
  input  logic                     dout_busy,
  output logic signed [QWIDTH-1:0] dout_data
);

  logic [SWIDTH-1:0]        shift_r;
  logic [DECW-1:0]          decim_r;
  logic [DECW-1:0]          phase_r;
  logic                     vld_p1;
  logic                     vld_p2;
  logic signed [OWIDTH:0]   data_p1;
  logic signed [QWIDTH-1:0] data_p2;
  logic signed [OWIDTH:0]   rnd;
  logic                     cfg_we;
  logic                     cfg_hit;
  logic                     din_acc;
  logic                     keep;
  logic                     load_p2;
  logic                     unused_cfg;

  function automatic logic [SWIDTH-1:0] clamp_shift(input logic [SWIDTH-1:0] v);
    return (int'(v) >= OWIDTH) ? SWIDTH'(OWIDTH - 1) : v;
  endfunction

  function automatic logic [DECW-1:0] clamp_decim(input logic [DECW-1:0] v);
    return (v == '0) ? DECW'(1) : v;
  endfunction

  function automatic logic signed [QWIDTH-1:0] sat_q(input logic signed [OWIDTH:0] v);
    logic signed [63:0] w;
    w = saturate(64'(v), QWIDTH);
    return w[QWIDTH-1:0];
  endfunction

  assign unused_cfg = ^cfg_data[DWIDTH-1:SWIDTH];

  assign cfg_busy   = vld_p1 | vld_p2;
  assign din_busy   = vld_p1 & vld_p2 & dout_busy;
  assign cfg_we     = cfg_valid & ~cfg_busy;
  assign cfg_hit    = cfg_we & ((cfg_addr == AWIDTH'(CFG_ADDR_SHIFT)) |
                                (cfg_addr == AWIDTH'(CFG_ADDR_DECIM)));
  assign din_acc    = din_valid & ~din_busy;
  assign keep       = din_acc & (phase_r == '0);
  assign load_p2    = ~vld_p2 | ~dout_busy;
  assign dout_valid = vld_p2;
  assign dout_data  = data_p2;

  fir_requant_round #(
    .OWIDTH(OWIDTH),
    .SWIDTH(SWIDTH)
  ) u_round (
    .din  (din_data),
    .shift(shift_r),
    .dout (rnd)
  );

  // Configuration and decimation phase; a cfg write on the same edge wins over the phase step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= SWIDTH'(SHIFT_RST);
      decim_r <= DECW'(DECIM_RST);
      phase_r <= '0;
    end else begin
      if (cfg_we && cfg_addr == AWIDTH'(CFG_ADDR_SHIFT))
        shift_r <= clamp_shift(cfg_data[SWIDTH-1:0]);
      if (cfg_we && cfg_addr == AWIDTH'(CFG_ADDR_DECIM))
        decim_r <= clamp_decim(cfg_data[DECW-1:0]);
      if (cfg_hit)
        phase_r <= '0;
      else if (din_acc)
        phase_r <= (phase_r >= decim_r - DECW'(1)) ? '0 : phase_r + DECW'(1);
    end
  end

  // Stage p1: rounded and shifted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (keep) begin
      vld_p1 <= 1'b1;
    end else if (load_p2) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (keep) data_p1 <= rnd;
  end

  // Stage p2: saturated output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= sat_q(data_p1);
    end
  end

endmodule

// File: tb/tb_fir_dout_requant.sv
// Scoreboard bench for fir_dout_requant with a behavioural arithmetic model.
module tb_fir_dout_requant;

  localparam int OW = 20;
  localparam int QW = 8;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SW = 5;
  localparam int DECW = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 cfg_valid;
  logic                 cfg_busy;
  logic [AW-1:0]        cfg_addr;
  logic [DW-1:0]        cfg_data;
  logic                 din_valid;
  logic                 din_busy;
  logic signed [OW-1:0] din_data;
  logic                 dout_valid;
  logic                 dout_busy;
  logic signed [QW-1:0] dout_data;

  fir_dout_requant #(
    .OWIDTH(OW), .QWIDTH(QW), .AWIDTH(AW), .DWIDTH(DW), .SWIDTH(SW), .DECW(DECW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_busy  (cfg_busy),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .din_valid (din_valid),
    .din_busy  (din_busy),
    .din_data  (din_data),
    .dout_valid(dout_valid),
    .dout_busy (dout_busy),
    .dout_data (dout_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int m_shift = 0;
  int m_decim = 1;
  int m_phase = 0;
  bit held = 0;
  int held_val = 0;
  int mon_e;
  bit rnd_bp = 0;
  bit acc;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: add half an LSB of the result, floor-divide by 2^s, clamp to QW bits.
  function automatic int ref_q(int x, int s);
    int y;
    y = x;
    if (s > 0) y = y + (1 << (s - 1));
    y = y >>> s;
    if (y > (1 << (QW - 1)) - 1) y = (1 << (QW - 1)) - 1;
    if (y < -(1 << (QW - 1))) y = -(1 << (QW - 1));
    return y;
  endfunction

  task automatic model_accept(int x);
    if (m_phase == 0) exp_q.push_back(ref_q(x, m_shift));
    m_phase = (m_phase + 1 >= m_decim) ? 0 : m_phase + 1;
  endtask

  task automatic model_cfg(int addr, int data);
    int v;
    if (addr == 0) begin
      v = data % 32;
      m_shift = (v >= OW) ? OW - 1 : v;
      m_phase = 0;
    end else if (addr == 1) begin
      v = data % 16;
      m_decim = (v == 0) ? 1 : v;
      m_phase = 0;
    end
  endtask

  // All driver tasks start and end just at a rising edge.
  task automatic send(int x);
    #1;
    din_valid = 1'b1;
    din_data  = OW'(x);
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (!din_busy) begin
        model_accept(x);
        @(posedge clk);
        return;
      end
      if (i >= 50) begin
        errors++;
        checks++;
        $display("FAIL send_timeout: din_busy stuck at %0d required 0", din_busy);
        @(posedge clk);
        return;
      end
      @(posedge clk);
    end
  endtask

  task automatic idle(int n);
    #1;
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic cfg_write(int addr, int data, output bit accepted);
    #1;
    din_valid = 1'b0;
    cfg_valid = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_data  = DW'(data);
    @(negedge clk);
    accepted = !cfg_busy;
    if (accepted) model_cfg(addr, data);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic cfg_retry(int addr, int data);
    bit a;
    for (int i = 0; i < 40; i++) begin
      cfg_write(addr, data, a);
      if (a) return;
    end
    errors++;
    checks++;
    $display("FAIL cfg_retry_timeout: cfg_busy %0d required 0", cfg_busy);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 300; i++) begin
      #1;
      if (exp_q.size() == 0 && !dout_valid) break;
      @(posedge clk);
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
    chk("drain_cfg_busy", cfg_busy, 0);
    @(posedge clk);
  endtask

  // Monitor: pop on every transfer, and require stalled output data to stay put.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      if (held && dout_valid) chk("hold_stable", dout_data, held_val);
      if (dout_valid && !dout_busy) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_out: got %0d required no output", dout_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dout", dout_data, mon_e);
        end
        held = 0;
      end else if (dout_valid) begin
        held = 1;
        held_val = dout_data;
      end else begin
        held = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      dout_busy = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    din_valid = 1'b0;
    din_data = '0;
    dout_busy = 1'b0;
    #12;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_data", dout_data, 0);
    chk("rst_din_busy", din_busy, 0);
    chk("rst_cfg_busy", cfg_busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);

    // shift 4, D 1, with a latency probe on the first sample
    cfg_write(0, 4, acc);
    chk("cfg_shift4_acc", acc, 1);
    send(56);
    #1;
    din_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle_k", dout_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_cycle_k1", dout_valid, 1);
    @(posedge clk);
    send(55);
    send(-24);
    idle(1);
    drain();

    // saturation at shift 0
    cfg_write(0, 0, acc);
    send(200); send(-300); send(127); send(-128);
    idle(1);
    drain();

    // decimation by 3
    cfg_write(1, 3, acc);
    for (int v = 1; v <= 9; v++) send(v);
    idle(1);
    drain();
    cfg_write(1, 3, acc);
    send(10); send(11); send(12);
    idle(1);
    drain();

    // backpressure on a continuous stream
    cfg_write(1, 1, acc);
    #1;
    dout_busy = 1'b1;
    send(1);
    send(2);
    #1;
    din_valid = 1'b1;
    din_data = OW'(3);
    @(negedge clk);
    chk("bp_din_busy", din_busy, 1);
    chk("bp_dout_hold", dout_data, 1);
    @(posedge clk);
    fork
      begin
        repeat (2) @(posedge clk);
        #1;
        dout_busy = 1'b0;
      end
      begin
        for (int v = 3; v <= 6; v++) send(v);
      end
    join
    idle(1);
    drain();

    // cfg refused while a sample is in flight, accepted after drain, addr 7 ignored
    send(9);
    cfg_write(0, 2, acc);
    chk("cfg_inflight_refused", acc, 0);
    drain();
    cfg_write(0, 2, acc);
    chk("cfg_idle_acc", acc, 1);
    send(6);
    idle(1);
    drain();
    cfg_write(7, 5, acc);
    chk("cfg_addr7_acc", acc, 1);
    send(6);
    idle(1);
    drain();

    // asynchronous reset with two samples buffered
    #1;
    dout_busy = 1'b1;
    send(3);
    send(4);
    #1;
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout_valid", dout_valid, 0);
    chk("mid_rst_din_busy", din_busy, 0);
    chk("mid_rst_cfg_busy", cfg_busy, 0);
    chk("mid_rst_dout_data", dout_data, 0);
    exp_q.delete();
    m_shift = 0;
    m_decim = 1;
    m_phase = 0;
    dout_busy = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    send(5);
    idle(1);
    drain();

    // randomized configuration, data, gaps and backpressure
    rnd_bp = 1;
    for (int r = 0; r < 20; r++) begin
      cfg_retry($urandom_range(0, 1), $urandom_range(0, 255));
      for (int n = 0; n < 30; n++) begin
        int x;
        logic signed [OW-1:0] w;
        if ($urandom_range(0, 1) == 1) begin
          x = $urandom_range(0, 600) - 300;
        end else begin
          w = OW'($urandom);
          x = int'(w);
        end
        send(x);
        if ($urandom_range(0, 4) == 0) idle(1);
      end
      idle(1);
    end
    rnd_bp = 0;
    @(posedge clk);
    #1;
    dout_busy = 1'b0;
    @(posedge clk);
    drain();

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
